pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch sequencer for the pipelined core. Owns the PC and issues one-outstanding fetches to instruction memory.
//  Presents fetched instructions to decode through a 1-entry output register backed by a 1-entry skid buffer.
//  Applies redirects driven by the JumpOP code from the jump controller, flushing wrong-path fetches.
//  Sits between imem and the IF/ID boundary.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  EXC_VEC    32'h0000_0080  exception vector (used only with PCSEQ_EXC_EN)
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  jump_op        in   2   00 seq, 01 branch taken, 10 jr, 11 j (jump-controller encoding)
//  redirect_valid in   1   jump_op is valid for the instruction on if_instr this cycle
//  branch_offset  in   32  sign-extended word offset for branches
//  jump_target    in   26  J-type index field
//  reg_target     in   32  rs value for jr
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (word aligned)
//  imem_ack       in   1   fetch data valid on imem_rdata this cycle
//  imem_rdata     in   32  fetched instruction
//  if_valid       out  1   if_instr/if_pc valid
//  if_ready       in   1   decode accepts if_instr this cycle
//  if_instr       out  32  instruction to decode
//  if_pc          out  32  PC of if_instr
// BEHAVIOUR
//  Reset: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, skid empty, state=S_RST.
//   rst mid-fetch abandons any outstanding request (req drops the next cycle, late ack ignored).
//  States: S_RST -> S_FETCH (first cycle after rst low). S_FETCH, S_HOLD, S_FLUSH as below.
//  Handshake: once imem_req=1, imem_req and imem_addr hold stable until imem_ack. Ack may arrive in the
//   cycle req first rises (0-wait). Only one fetch is outstanding.
//  S_FETCH: raise req with addr=pc when the skid buffer is empty. On ack: pc<=pc+4; instr goes to the output
//   register if (!if_valid || if_ready), else to skid and the state moves to S_HOLD (req=0).
//  S_HOLD: on if_ready, skid -> output register, return to S_FETCH. Throughput: 1 instr/cycle with 0-wait imem.
//  Redirect: taken when redirect_valid && if_valid && if_ready && jump_op!=00. Targets (P4 = if_pc+4):
//   01: P4 + (branch_offset<<2), mod 2^32 wrap. 10: {reg_target[31:2],2'b00}. 11: {P4[31:28],jump_target,2'b00}.
//   Effect next cycle: pc<=target, if_valid=0, skid cleared. No delay slot.
//   If a request is outstanding with no ack this cycle -> S_FLUSH: keep req/addr stable, discard data on ack, then
//   S_FETCH at target. If ack coincides with redirect, that data is discarded; the target fetch issues next cycle.
//  jump_op=00 with redirect_valid: no effect. redirect_valid without if_valid&&if_ready: ignored.
//  Priority: rst > exception (if enabled) > redirect > sequential.
// CONFIGURATION
//  PCSEQ_EXC_EN defined: adds ports exc_req (in,1) and epc (out,32, reset 0). exc_req with if_valid&&if_ready
//   latches epc<=if_pc and redirects to EXC_VEC using the same flush rules; overrides a same-cycle redirect.
//  PCSEQ_EXC_EN undefined: ports absent, EXC_VEC unused, no exception logic.
// STRUCTURE
//  Shared package pcseq_pkg: JumpOP codes JOP_SEQ/JOP_BR/JOP_JR/JOP_J, state encodings S_RST/S_FETCH/S_HOLD/S_FLUSH.
//  Sub-module pc_target_calc (combinational: jump_op, if_pc, offsets -> target). FSM/buffers stay in the top level.
// TESTING
//  1 rst 3 cycles, 0-wait imem, if_ready=1 -> imem_addr 0,4,8,... one per cycle; if_pc matches the addresses.
//  2 if_ready=0 for 4 cycles mid-stream -> no instr lost or duplicated, req low while the skid is full, order preserved.
//  3 jump_op=01, if_pc=0x10, offset=-2 -> next imem_addr=0x0C; the in-flight instr from 0x14 is never presented.
//  4 imem latency 3, jr to 0x40 while fetch 0x20 is outstanding -> addr holds 0x20 until ack, data dropped, then 0x40.
//  5 jump_op=11, if_pc=0xF000_0000, idx=26'h10 -> target 0xF000_0040; branch offset wrap past 0xFFFF_FFFC -> 0x0.
//  6 rst asserted with a fetch outstanding -> all outputs at reset values next cycle; late ack produces no if_valid.

Source files
------------

// File: rtl/pcseq_pkg.sv
// pcseq_pkg: types shared by the fetch sequencer and its target calculator.
//  - jump_op_e : jump-controller encoding carried on jump_op
//  - state_e   : fetch sequencer states
//  - fetch_entry_t : one fetched instruction plus the PC it was fetched from
package pcseq_pkg;

    typedef enum logic [1:0] {
        JOP_SEQ = 2'b00,
        JOP_BR  = 2'b01,
        JOP_JR  = 2'b10,
        JOP_J   = 2'b11
    } jump_op_e;

    typedef enum logic [1:0] {
        S_RST   = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10,
        S_FLUSH = 2'b11
    } state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target for the instruction at if_pc.
// Ports:
//  jump_op       in  2   jump-controller code (seq / branch / jr / j)
//  if_pc         in  32  PC of the instruction causing the redirect
//  branch_offset in  32  sign-extended word offset
//  jump_target   in  26  J-type index field
//  reg_target    in  32  rs value for jr
//  target        out 32  next fetch address
module pc_target_calc (
    input  logic [1:0]  jump_op,
    input  logic [31:0] if_pc,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_target,
    output logic [31:0] target
);
    import pcseq_pkg::*;

    logic [31:0] p4;
    // Bits shifted out of the word offset and the byte bits of rs play no part.
    logic        unused_bits;

    assign p4          = if_pc + INSTR_BYTES;
    assign unused_bits = ^{branch_offset[31:30], reg_target[1:0]};

    always_comb begin
        target = p4;
        case (jump_op_e'(jump_op))
            JOP_BR:  target = p4 + {branch_offset[29:0], 2'b00};
            JOP_JR:  target = {reg_target[31:2], 2'b00};
            JOP_J:   target = {p4[31:28], jump_target, 2'b00};
            default: target = p4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer. Owns the PC, keeps one imem fetch outstanding,
// and presents instructions to decode through an output register backed by a
// one-entry skid buffer. Redirects from the jump controller flush wrong-path data.
// Optional feature macro: PCSEQ_EXC_EN (adds exc_req / epc and the EXC_VEC redirect).
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  jump_op, redirect_valid      redirect request for the instruction on if_instr
//  branch_offset, jump_target, reg_target   redirect operands
//  imem_req/imem_addr (out), imem_ack/imem_rdata (in)   instruction memory handshake
//  if_valid/if_instr/if_pc (out), if_ready (in)          decode handshake
//  exc_req (in), epc (out)      only with PCSEQ_EXC_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  jump_op,
    input  logic        redirect_valid,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef PCSEQ_EXC_EN
    ,
    input  logic        exc_req,
    output logic [31:0] epc
`endif
);
    import pcseq_pkg::*;

    state_e       state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  flush_addr_reg, flush_addr_next;
    logic         out_valid_reg, out_valid_next;
    fetch_entry_t out_reg, out_next;
    logic         skid_valid_reg, skid_valid_next;
    fetch_entry_t skid_reg, skid_next;

    logic [31:0]  calc_target;
    logic [31:0]  redirect_pc;
    logic         take_redirect;
    logic         do_redirect;

    pc_target_calc u_target (
        .jump_op       (jump_op),
        .if_pc         (out_reg.pc),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .target        (calc_target)
    );

    // A redirect is tied to decode consuming the instruction that caused it.
    assign take_redirect = redirect_valid && out_valid_reg && if_ready
                           && (jump_op != JOP_SEQ);

`ifdef PCSEQ_EXC_EN
    logic        take_exc;
    logic [31:0] epc_reg;

    assign take_exc    = exc_req && out_valid_reg && if_ready;
    assign do_redirect = take_exc || take_redirect;
    assign redirect_pc = take_exc ? EXC_VEC : calc_target;
    assign epc         = epc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_reg <= 32'h0;
        end else if (take_exc) begin
            epc_reg <= out_reg.pc;
        end
    end
`else
    localparam logic [31:0] unused_exc_vec = EXC_VEC;

    assign do_redirect = take_redirect;
    assign redirect_pc = calc_target;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_RST;
            pc_reg         <= RESET_PC;
            flush_addr_reg <= RESET_PC;
            out_valid_reg  <= 1'b0;
            out_reg        <= '0;
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            flush_addr_reg <= flush_addr_next;
            out_valid_reg  <= out_valid_next;
            out_reg        <= out_next;
            skid_valid_reg <= skid_valid_next;
            skid_reg       <= skid_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        flush_addr_next = flush_addr_reg;
        out_valid_next  = out_valid_reg;
        out_next        = out_reg;
        skid_valid_next = skid_valid_reg;
        skid_next       = skid_reg;

        case (state_reg)
            S_RST: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (do_redirect) begin
                    pc_next         = redirect_pc;
                    out_valid_next  = 1'b0;
                    skid_valid_next = 1'b0;
                    // Fetch still in flight: wait it out at its own address.
                    // If it acks now, its data is simply dropped.
                    if (!imem_ack) begin
                        state_next      = S_FLUSH;
                        flush_addr_next = pc_reg;
                    end
                end else begin
                    if (out_valid_reg && if_ready) begin
                        out_valid_next = 1'b0;
                    end
                    if (imem_ack) begin
                        pc_next = pc_reg + INSTR_BYTES;
                        if (!out_valid_reg || if_ready) begin
                            out_valid_next = 1'b1;
                            out_next       = '{instr: imem_rdata, pc: pc_reg};
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_next       = '{instr: imem_rdata, pc: pc_reg};
                            state_next      = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (do_redirect) begin
                    pc_next         = redirect_pc;
                    out_valid_next  = 1'b0;
                    skid_valid_next = 1'b0;
                    state_next      = S_FETCH;
                end else if (if_ready) begin
                    out_next        = skid_reg;
                    skid_valid_next = 1'b0;
                    state_next      = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (imem_ack) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_RST;
        endcase
    end

    // Outputs. The request is held through FLUSH at the abandoned address so
    // the memory handshake is never withdrawn before its ack.
    always_comb begin
        imem_req  = ((state_reg == S_FETCH) && !skid_valid_reg) || (state_reg == S_FLUSH);
        imem_addr = (state_reg == S_FLUSH) ? flush_addr_reg : pc_reg;
        if_valid  = out_valid_reg;
        if_instr  = out_reg.instr;
        if_pc     = out_reg.pc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a latency-configurable
// imem model (instruction word = address + 0x1000_0000).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  jump_op;
    logic        redirect_valid;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef PCSEQ_EXC_EN
    logic        exc_req = 1'b0;
    logic [31:0] epc;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int   lat = 0;
    int   cnt = 0;
    logic ack_force = 1'b0;

    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];

    logic        pend_q = 1'b0;
    logic [31:0] pend_addr_q = '0;

    localparam logic [31:0] IOFS = 32'h1000_0000;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .jump_op        (jump_op),
        .redirect_valid (redirect_valid),
        .branch_offset  (branch_offset),
        .jump_target    (jump_target),
        .reg_target     (reg_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef PCSEQ_EXC_EN
        ,
        .exc_req        (exc_req),
        .epc            (epc)
`endif
    );

    always #5 clk = ~clk;

    // imem model: ack once the request has been held for 'lat' cycles.
    assign imem_ack   = (imem_req && (cnt >= lat)) || ack_force;
    assign imem_rdata = imem_addr + IOFS;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) cnt <= 0;
        else                       cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepted-instruction log and request-stability monitor.
    always @(negedge clk) begin
        if (if_valid && if_ready) begin
            acc_pc.push_back(if_pc);
            acc_instr.push_back(if_instr);
        end
        if (pend_q) begin
            check("req_hold", {31'b0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, pend_addr_q);
        end
        pend_q      = imem_req && !imem_ack && !rst;
        pend_addr_q = imem_addr;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        jump_op        = 2'b00;
        branch_offset  = '0;
        jump_target    = '0;
        reg_target     = '0;
        if_ready       = 1'b1;
    endtask

    // Leaves the bench at cycle c0: first cycle in S_FETCH.
    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        step(3);
        rst = 1'b0;
        step(1);
        acc_pc.delete();
        acc_instr.delete();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!if_valid && k < budget) begin
            step(1);
            k++;
        end
        check(tag, {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- 1: reset state, 0-wait streaming ----
        rst = 1'b1;
        idle_inputs();
        step(3);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        rst = 1'b0;
        step(1);
        acc_pc.delete();
        acc_instr.delete();
        check("t1_req", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("t1_addr", imem_addr, 32'(4 * k));
            check("t1_pc", if_pc, 32'(4 * (k - 1)));
            check("t1_instr", if_instr, 32'(4 * (k - 1)) + IOFS);
        end
        // ---- 2: decode stall for 4 cycles (now at c5) ----
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("t2_req_low", {31'b0, imem_req}, 32'd0);
            check("t2_pc_held", if_pc, 32'h10);
        end
        step(1);
        if_ready = 1'b1;
        step(2);
        check("t2_pc_after", if_pc, 32'h18);
        check("t2_count", acc_pc.size(), 32'd6);
        for (int k = 0; k < 6 && k < acc_pc.size(); k++) begin
            check("t2_order_pc", acc_pc[k], 32'(4 * k));
            check("t2_order_instr", acc_instr[k], 32'(4 * k) + IOFS);
        end

        // ---- 7: jump_op=00 and redirect without if_ready are ignored ----
        reset_dut();
        step(2);
        redirect_valid = 1'b1;
        jump_op        = 2'b00;
        reg_target     = 32'h80;
        step(1);
        check("t7_seq_addr", imem_addr, 32'h0C);
        check("t7_seq_pc", if_pc, 32'h08);
        jump_op  = 2'b10;
        if_ready = 1'b0;
        step(1);
        check("t7_nr_pc", if_pc, 32'h08);
        check("t7_nr_req", {31'b0, imem_req}, 32'd0);
        idle_inputs();
        step(1);
        check("t7_nr_next", if_pc, 32'h0C);
        check("t7_nr_addr", imem_addr, 32'h10);

        // ---- 3: taken branch, offset -2 at if_pc 0x10 ----
        reset_dut();
        step(5);
        check("t3_at", if_pc, 32'h10);
        redirect_valid = 1'b1;
        jump_op        = 2'b01;
        branch_offset  = 32'hFFFF_FFFE;
        step(1);
        idle_inputs();
        check("t3_flushed", {31'b0, if_valid}, 32'd0);
        check("t3_addr", imem_addr, 32'h0C);
        step(1);
        check("t3_next_pc", if_pc, 32'h0C);
        check("t3_acc_count", acc_pc.size(), 32'd5);

        // ---- 4: jr while a 3-cycle fetch of 0x20 is outstanding ----
        reset_dut();
        step(8);
        check("t4_pre_addr", imem_addr, 32'h20);
        lat      = 3;
        if_ready = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        jump_op        = 2'b10;
        reg_target     = 32'h0000_0043;
        if_ready       = 1'b1;
        step(1);
        idle_inputs();
        check("t4_flush_addr", imem_addr, 32'h20);
        check("t4_flush_valid", {31'b0, if_valid}, 32'd0);
        step(1);
        check("t4_ack_addr", imem_addr, 32'h20);
        step(1);
        check("t4_target_addr", imem_addr, 32'h40);
        check("t4_dropped", {31'b0, if_valid}, 32'd0);
        wait_valid("t4_wait", 10);
        check("t4_pc", if_pc, 32'h40);
        check("t4_instr", if_instr, 32'h40 + IOFS);
        lat = 0;

        // ---- 5: J-type at 0xF000_0000 and branch wrap ----
        reset_dut();
        step(1);
        redirect_valid = 1'b1;
        jump_op        = 2'b10;
        reg_target     = 32'hF000_0000;
        step(1);
        idle_inputs();
        step(1);
        check("t5_at", if_pc, 32'hF000_0000);
        redirect_valid = 1'b1;
        jump_op        = 2'b11;
        jump_target    = 26'h10;
        step(1);
        idle_inputs();
        check("t5_j_addr", imem_addr, 32'hF000_0040);
        step(1);
        redirect_valid = 1'b1;
        jump_op        = 2'b10;
        reg_target     = 32'hFFFF_FFF8;
        step(1);
        idle_inputs();
        step(1);
        check("t5_wrap_at", if_pc, 32'hFFFF_FFF8);
        redirect_valid = 1'b1;
        jump_op        = 2'b01;
        branch_offset  = 32'h1;
        step(1);
        idle_inputs();
        check("t5_wrap_addr", imem_addr, 32'h0);
        step(1);
        check("t5_wrap_pc", if_pc, 32'h0);

        // ---- 6: reset with a fetch outstanding, late ack ignored ----
        reset_dut();
        lat = 3;
        step(1);
        rst = 1'b1;
        step(1);
        check("t6_req", {31'b0, imem_req}, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_valid", {31'b0, if_valid}, 32'd0);
        check("t6_instr", if_instr, 32'h0);
        check("t6_pc", if_pc, 32'h0);
        rst       = 1'b0;
        ack_force = 1'b1;
        step(1);
        ack_force = 1'b0;
        check("t6_late_ack", {31'b0, if_valid}, 32'd0);
        check("t6_refetch", imem_addr, 32'h0);
        wait_valid("t6_wait", 10);
        check("t6_first_pc", if_pc, 32'h0);
        lat = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
